gray_conv_arbiter: RTL and testbench
====================================

# gray_conv_arbiter

Round-robin scheduler that shares one combinational Gray-to-binary converter among `N_REQ` requesters (e.g. absolute-encoder channels). Each requester presents a Gray word with a valid/ready handshake. The arbiter grants one requester per cycle, converts the word, and places the binary result in a single registered output slot tagged with the requester ID. Per requester, it also flags any sample that differs from that requester's previous accepted sample in more than one bit (Gray-step violation).

## Interface
Parameters:
- `N_REQ`, 4 — number of requesters; power of two, ≥ 2.
- `W`, 4 — Gray/binary word width; ≥ 2.

Ports (`IDW = $clog2(N_REQ)`):
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `req_valid`  in  N_REQ  — bit i: requester i has a word.
- `req_gray`  in  N_REQ*W  — requester i's word at `[i*W +: W]`.
- `req_ready`  out  N_REQ  — one-hot or zero; bit i high = requester i's word is accepted this cycle.
- `out_valid`  out  1  — output slot holds a result.
- `out_bin`  out  W  — binary value of the accepted Gray word.
- `out_id`  out  IDW  — index of the requester that produced it.
- `out_err`  out  1  — Gray-step violation on this sample.
- `out_ready`  in  1  — consumer takes the slot when `out_valid && out_ready`.

## Operation
- `can_accept = !out_valid || out_ready`.
- Arbitration:
  - Search `req_valid` starting at `rr_ptr`, wrapping modulo `N_REQ`. The first set bit is `gnt`.
  - `req_ready[gnt] = can_accept`; all other `req_ready` bits are 0.
  - `req_ready` depends combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- On acceptance (`req_valid[gnt] && req_ready[gnt]`):
  - Output slot loads `out_bin = g2b(req_gray[gnt])`, `out_id = gnt`, `out_err` as defined below, and `out_valid = 1`.
  - `rr_ptr <= (gnt + 1) mod N_REQ`.
  - `last_gray[gnt] <= req_gray[gnt]`; `seen[gnt] <= 1`.
- If there is no acceptance and `out_valid && out_ready`, then `out_valid <= 0`.
- `rr_ptr` changes only on acceptance. An idle cycle or a stalled cycle leaves it unchanged.
- Conversion `g2b`: `b[W-1] = g[W-1]`; `b[k] = b[k+1] ^ g[k]` for k = W-2 down to 0. Width is preserved; there is no overflow.
- Step check: `out_err = seen[gnt] && (popcount(req_gray[gnt] ^ last_gray[gnt]) > 1)`.
  - Identical consecutive samples (distance 0) are legal.
  - Wrap-around, e.g. W=4 `1000` → `0000`, is distance 1 and legal.
  - The first sample after reset never errors.
- `out_err` is informational only. The sample is still converted and delivered, and `last_gray` is still updated.
- Output slot, while `out_valid && !out_ready`: `out_bin`, `out_id` and `out_err` hold stable and no request is accepted.

## Timing
- Latency: accept in cycle t → `out_valid` high in cycle t+1.
- Throughput: one word per cycle when `out_ready` is held high.
- Back-to-back transfers: slot consumed and refilled in the same cycle (simultaneous drain + fill) with no bubble.
- Reset values:
  - `out_valid = 0`, `out_bin = 0`, `out_id = 0`, `out_err = 0`.
  - `rr_ptr = 0`; all `seen = 0`; all `last_gray = 0`.
  - `req_ready = 0` during reset: `rst` gates `can_accept`.
- Reset mid-operation: a pending output is discarded. A request presented in the reset cycle is not accepted.
- Fairness: with all requesters continuously valid and `out_ready` = 1, grants go 0, 1, …, N_REQ-1, 0, …. A continuously valid requester waits at most N_REQ-1 accepted transfers.

## Structure
- Shared package `gray_pkg`:
  - `function g2b`, width-generic via parameter.
  - `function popcount`.
  - Constants `GRAY_W_DEFAULT = 4`, `GRAY_NREQ_DEFAULT = 4`.
- Sub-module `gray2bin`: purely combinational, parameter `W`, ports `g`, `b`. This is the single shared converter, instanced once on the granted word.
- The arbiter (round-robin search, per-requester `last_gray`/`seen` arrays, output slot) lives in `gray_conv_arbiter`.

## Test plan
- **Reset:** assert `rst` for 2 cycles with all `req_valid` = 1 → `req_ready` = 0 and `out_valid` = 0 throughout; first grant after release goes to requester 0.
- **Conversion sweep:** requester 2 alone sends Gray 0..15 in 4-bit Gray order with `out_ready` = 1 → `out_bin` = 0..15, `out_id` = 2, `out_err` = 0 on every sample, including the wrap `1000` → `0000`.
- **Round-robin:** all four valid, `out_ready` = 1 → `out_id` sequence 0, 1, 2, 3, 0, 1; one result per cycle after one cycle of latency.
- **Backpressure:** slot holds Gray `0110` → `out_bin` = `0100`; hold `out_ready` = 0 for 3 cycles → output stable, `req_ready` = 0, `rr_ptr` unchanged. Then `out_ready` = 1 → next grant and the refill happen in that same cycle.
- **Step error:** requester 1 sends `0000` then `0011` → second result `out_bin` = `0010`, `out_err` = 1. Next `0010` → `out_err` = 0.
- **Per-requester history:** requester 0 sends `0111`, requester 3 sends `1000`, requester 0 sends `0101` → all `out_err` = 0, because history is tracked separately per requester.

Source files
------------

// File: rtl/gray_pkg.sv
// gray_pkg: shared constants and Gray-code helper functions
package gray_pkg;
  localparam int GRAY_W_DEFAULT = 4;
  localparam int GRAY_NREQ_DEFAULT = 4;
  localparam int GRAY_MAX_W = 32;
  function automatic logic [GRAY_MAX_W-1:0] g2b(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int k = GRAY_MAX_W-2; k >= 0; k--) b[k] = b[k+1] ^ g[k];
    return b;
  endfunction
  function automatic int unsigned popcount(input logic [GRAY_MAX_W-1:0] v);
    int unsigned c;
    c = 0;
    for (int k = 0; k < GRAY_MAX_W; k++) c += 32'(v[k]);
    return c;
  endfunction
endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary converter; zero-extension leaves low bits intact
module gray2bin
  import gray_pkg::*;
#(
  parameter int W = GRAY_W_DEFAULT
) (
  input  logic [W-1:0] g,
  output logic [W-1:0] b
);
  assign b = W'(g2b(GRAY_MAX_W'(g)));
endmodule

// File: rtl/gray_conv_arbiter.sv
// gray_conv_arbiter: round-robin share of one Gray converter with per-requester step check
module gray_conv_arbiter
  import gray_pkg::*;
#(
  parameter int N_REQ = GRAY_NREQ_DEFAULT,
  parameter int W = GRAY_W_DEFAULT,
  localparam int IDW = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_gray,
  output logic [N_REQ-1:0]   req_ready,
  output logic               out_valid,
  output logic [W-1:0]       out_bin,
  output logic [IDW-1:0]     out_id,
  output logic               out_err,
  input  logic               out_ready
);
  logic [IDW-1:0] r_rr_ptr, w_gnt, r_out_id;
  logic           w_found, w_can_accept, w_accept, w_err, r_out_valid, r_out_err;
  logic [W-1:0]   w_gray, w_bin, r_out_bin;
  logic [W-1:0]   r_last [N_REQ];
  logic [N_REQ-1:0] r_seen;
  // first valid requester at or after rr_ptr; downward loop so the nearest one wins
  always_comb begin
    w_gnt = r_rr_ptr;
    w_found = 1'b0;
    for (int i = N_REQ-1; i >= 0; i--)
      if (req_valid[r_rr_ptr + IDW'(i)]) begin
        w_gnt = r_rr_ptr + IDW'(i);
        w_found = 1'b1;
      end
  end
  assign w_can_accept = !rst && (!r_out_valid || out_ready);
  assign w_accept = w_found && w_can_accept;
  assign req_ready = w_accept ? N_REQ'(1) << w_gnt : '0;
  assign w_gray = req_gray[w_gnt*W +: W];
  assign w_err = r_seen[w_gnt] && (popcount(GRAY_MAX_W'(w_gray ^ r_last[w_gnt])) > 1);
  gray2bin #(.W(W)) u_g2b (.g(w_gray), .b(w_bin));
  // output slot and round-robin pointer; pointer moves only on acceptance
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_bin <= '0;
      r_out_id <= '0;
      r_out_err <= 1'b0;
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_bin <= w_bin;
      r_out_id <= w_gnt;
      r_out_err <= w_err;
      r_rr_ptr <= w_gnt + IDW'(1);
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
  // per-requester history of the last accepted Gray word
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seen <= '0;
      for (int i = 0; i < N_REQ; i++) r_last[i] <= '0;
    end else if (w_accept) begin
      r_seen[w_gnt] <= 1'b1;
      r_last[w_gnt] <= w_gray;
    end
  end
  assign out_valid = r_out_valid;
  assign out_bin = r_out_bin;
  assign out_id = r_out_id;
  assign out_err = r_out_err;
endmodule

// File: tb/tb_gray_conv_arbiter.sv
// tb_gray_conv_arbiter: directed self-checking bench; outputs packed as {valid,err,id,bin}
module tb_gray_conv_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] req_valid;
  logic [15:0] req_gray;
  logic [3:0] req_ready;
  logic out_valid;
  logic [3:0] out_bin;
  logic [1:0] out_id;
  logic out_err;
  logic out_ready;
  int errors = 0;
  int checks = 0;

  gray_conv_arbiter #(.N_REQ(4), .W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_gray(req_gray),
    .req_ready(req_ready), .out_valid(out_valid), .out_bin(out_bin),
    .out_id(out_id), .out_err(out_err), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] slot();
    return {out_valid, out_err, out_id, out_bin};
  endfunction

  function automatic logic [7:0] rdy();
    return {4'b0, req_ready};
  endfunction

  initial begin
    logic [3:0] g;
    rst = 1'b1;
    req_valid = 4'hF;
    req_gray = '0;
    out_ready = 1'b1;
    // reset: two cycles, all requesters valid
    #1;
    chk("rst_rdy0", rdy(), 8'h00);
    chk("rst_slot0", slot(), 8'h00);
    tick;
    chk("rst_rdy1", rdy(), 8'h00);
    chk("rst_slot1", slot(), 8'h00);
    tick;
    chk("rst_rdy2", rdy(), 8'h00);
    chk("rst_slot2", slot(), 8'h00);
    rst = 1'b0;
    #1;
    chk("first_rdy", rdy(), 8'h01);
    tick;
    chk("first_slot", slot(), {1'b1, 1'b0, 2'd0, 4'd0});
    req_valid = 4'h0;
    tick;
    chk("drain", {7'b0, out_valid}, 8'h00);
    // conversion sweep on requester 2, including wrap 1000 -> 0000
    for (int i = 0; i <= 16; i++) begin
      g = 4'(i % 16);
      req_gray[8 +: 4] = g ^ (g >> 1);
      req_valid = 4'b0100;
      #1;
      chk("sweep_rdy", rdy(), 8'h04);
      tick;
      chk("sweep_slot", slot(), {1'b1, 1'b0, 2'd2, g});
    end
    // round-robin after a fresh reset; words convert to their own index
    req_valid = 4'h0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_again", slot(), 8'h00);
    req_gray = {4'b0010, 4'b0011, 4'b0001, 4'b0000};
    req_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("rr_slot", slot(), {1'b1, 1'b0, 2'(i % 4), 4'(i % 4)});
    end
    // reset mid-operation: pending result discarded, request ignored
    rst = 1'b1;
    #1;
    chk("midrst_rdy", rdy(), 8'h00);
    tick;
    rst = 1'b0;
    chk("midrst_slot", slot(), 8'h00);
    // backpressure: Gray 0110 -> 0100 held while out_ready low
    req_valid = 4'b0001;
    req_gray = {4'b0000, 4'b0000, 4'b0000, 4'b0110};
    tick;
    chk("bp_load", slot(), {1'b1, 1'b0, 2'd0, 4'b0100});
    req_valid = 4'hF;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_rdy", rdy(), 8'h00);
      tick;
      chk("bp_hold", slot(), {1'b1, 1'b0, 2'd0, 4'b0100});
    end
    out_ready = 1'b1;
    #1;
    chk("bp_refill_rdy", rdy(), 8'h02);
    tick;
    chk("bp_refill", slot(), {1'b1, 1'b0, 2'd1, 4'd0});
    req_valid = 4'h0;
    tick;
    chk("bp_drain", {7'b0, out_valid}, 8'h00);
    // step error on requester 1 (its history holds 0000)
    req_valid = 4'b0010;
    req_gray[4 +: 4] = 4'b0000;
    tick;
    chk("step_a", slot(), {1'b1, 1'b0, 2'd1, 4'b0000});
    req_gray[4 +: 4] = 4'b0011;
    tick;
    chk("step_err", slot(), {1'b1, 1'b1, 2'd1, 4'b0010});
    req_gray[4 +: 4] = 4'b0010;
    tick;
    chk("step_ok", slot(), {1'b1, 1'b0, 2'd1, 4'b0011});
    // per-requester history: requester 0 last saw 0110, requester 3 unseen
    req_valid = 4'b0001;
    req_gray[0 +: 4] = 4'b0111;
    tick;
    chk("hist_r0a", slot(), {1'b1, 1'b0, 2'd0, 4'b0101});
    req_valid = 4'b1000;
    req_gray[12 +: 4] = 4'b1000;
    tick;
    chk("hist_r3", slot(), {1'b1, 1'b0, 2'd3, 4'b1111});
    req_valid = 4'b0001;
    req_gray[0 +: 4] = 4'b0101;
    tick;
    chk("hist_r0b", slot(), {1'b1, 1'b0, 2'd0, 4'b0110});
    req_gray[0 +: 4] = 4'b1010;
    tick;
    chk("hist_r0_jump", slot(), {1'b1, 1'b1, 2'd0, 4'b1100});
    req_valid = 4'h0;
    tick;
    chk("final_drain", {7'b0, out_valid}, 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
